risc_register_file: RTL and testbench
=====================================

// Module: risc_register_file
// PURPOSE
//  32 x XLEN integer register file; x0 is hardwired to zero.
//  Serves the two operand-read ports (a, b) driven by the instruction handler using a valid/ack handshake.
//  Accepts result writes from the ALU writeback path through its own valid/ack handshake.
//  Sits directly upstream of the handler's operand-to-ALU stage.
// PARAMETERS
//  XLEN          32  register/data width
//  REG_ADDR_W    5   register address width (2**REG_ADDR_W registers)
//  READ_LATENCY  1   cycles from request acceptance to ack (>=1)
// PORTS
//  clk                  in   1           clock, all logic on posedge
//  reset                in   1           asynchronous, active-low reset
//  reg_rd_addr_a        in   REG_ADDR_W  port a register index
//  reg_rd_addr_a_valid  in   1           port a request, level, held until ack seen
//  reg_rd_data_a        out  XLEN        port a read data
//  reg_rd_data_a_ack    out  1           port a one-cycle done pulse
//  reg_rd_addr_b        in   REG_ADDR_W  port b register index
//  reg_rd_addr_b_valid  in   1           port b request
//  reg_rd_data_b        out  XLEN        port b read data
//  reg_rd_data_b_ack    out  1           port b one-cycle done pulse
//  reg_wr_addr          in   REG_ADDR_W  write register index
//  reg_wr_data          in   XLEN        write data
//  reg_wr_valid         in   1           write request, level, held until ack
//  reg_wr_ack           out  1           one-cycle pulse: write committed
// BEHAVIOUR
//  Reset (reset==0, async)
//   - all registers = 0; all read-port FSMs and the write FSM = IDLE.
//   - reg_rd_data_a/b = 0; all acks = 0.
//   - any in-flight request is dropped and never acked.
//  Read port FSM (identical per port): IDLE -> WAIT -> ACK -> IDLE
//   - IDLE: on valid==1, latch addr and load cnt = READ_LATENCY-1.
//     Next state is WAIT, or ACK directly when READ_LATENCY==1.
//   - WAIT: decrement cnt each cycle; on cnt==1 go to ACK.
//   - Entering ACK: load reg_rd_data from the array at the latched addr.
//     A write committing on that same edge to the same addr is bypassed, giving the new value.
//     addr 0 always reads 0.
//   - ACK: ack=1 for exactly one cycle, then IDLE. Valid is ignored in ACK and on the ack edge.
//     No request is accepted until IDLE.
//   - Read data stays stable after ack until the next data load.
//   - Ack latency: valid first seen high in cycle 0 -> ack high in cycle READ_LATENCY.
//   - Addr changes after acceptance are ignored.
//   - Ports a and b are independent. Requests accepted on the same edge ack on the same cycle.
//     The handler requires coincident a/b acks.
//  Write FSM: IDLE -> ACK -> IDLE
//   - IDLE: on reg_wr_valid, commit reg_wr_data to reg_wr_addr on that edge and go to ACK.
//   - ACK: reg_wr_ack=1 for one cycle; reg_wr_valid is ignored.
//   - Writes to addr 0 are acked but discarded.
//  Simultaneous events
//   - a and b reading the same register is legal; both return the same value.
//   - Read and write to the same register on the data-load edge: the new value is returned.
//   - Write commit on the request-accept edge with READ_LATENCY>1: the new value is returned.
//  Arithmetic
//   - cnt width = $clog2(READ_LATENCY)+1, unsigned; no wrap possible.
// STRUCTURE
//  Shared package risc_pkg
//   - XLEN, REG_ADDR_W localparams.
//   - typedef enum logic[1:0] {RP_IDLE, RP_WAIT, RP_ACK} reg_port_state_t.
//  Sub-module reg_read_port
//   - FSM, counter, addr latch, data register; instantiated twice.
//  Top level
//   - Owns the array, write FSM, bypass muxes and x0 forcing.
// TESTING
//  1. Reset: hold reset=0 mid-request -> acks 0, data 0; after release every register reads 0.
//  2. Write x5=0xDEADBEEF, then read a=x5, b=x0 (L=1) -> both acks in cycle 1; a=0xDEADBEEF, b=0.
//  3. Write x0=0x1234 -> reg_wr_ack pulses 1 cycle; subsequent read x0 returns 0.
//  4. L=3: valid a,b at cycle 0; write x7=0x55 in cycle 2 -> acks exactly cycle 3; x7 reads 0x55.
//  5. Hold valid high through ack -> single ack pulse only.
//     Addr changed during WAIT -> data from the originally latched addr.
//  6. Assert reset during WAIT -> no ack; after release a fresh request completes normally.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared widths and state encodings for the integer register file
package risc_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {RP_IDLE, RP_WAIT, RP_ACK} reg_port_state_t;
  typedef enum logic {WR_IDLE, WR_ACK} reg_wr_state_t;
endpackage

// File: rtl/risc_register_file_if.sv
// rtl/risc_register_file_if.sv - operand read and writeback handshakes of the register file
interface risc_register_file_if;
  import risc_pkg::*;

  logic [REG_ADDR_W-1:0] reg_rd_addr_a;
  logic                  reg_rd_addr_a_valid;
  logic [XLEN-1:0]       reg_rd_data_a;
  logic                  reg_rd_data_a_ack;
  logic [REG_ADDR_W-1:0] reg_rd_addr_b;
  logic                  reg_rd_addr_b_valid;
  logic [XLEN-1:0]       reg_rd_data_b;
  logic                  reg_rd_data_b_ack;
  logic [REG_ADDR_W-1:0] reg_wr_addr;
  logic [XLEN-1:0]       reg_wr_data;
  logic                  reg_wr_valid;
  logic                  reg_wr_ack;

  modport master (
    output reg_rd_addr_a, reg_rd_addr_a_valid, reg_rd_addr_b, reg_rd_addr_b_valid,
    output reg_wr_addr, reg_wr_data, reg_wr_valid,
    input  reg_rd_data_a, reg_rd_data_a_ack, reg_rd_data_b, reg_rd_data_b_ack, reg_wr_ack
  );

  modport slave (
    input  reg_rd_addr_a, reg_rd_addr_a_valid, reg_rd_addr_b, reg_rd_addr_b_valid,
    input  reg_wr_addr, reg_wr_data, reg_wr_valid,
    output reg_rd_data_a, reg_rd_data_a_ack, reg_rd_data_b, reg_rd_data_b_ack, reg_wr_ack
  );
endinterface

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one operand read port: request latch, latency counter, data register
module reg_read_port
  import risc_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]       load_value,
  output logic [REG_ADDR_W-1:0] load_addr,
  output logic [XLEN-1:0]       data,
  output logic                  ack
);
  localparam int CNT_W = $clog2(READ_LATENCY) + 1;

  reg_port_state_t       state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [REG_ADDR_W-1:0] addr_q, addr_next;
  logic                  load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RP_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data   <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      addr_q <= addr_next;
      if (load) data <= load_value;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = addr_q;
    load       = 1'b0;
    case (state)
      RP_IDLE: begin
        if (valid) begin
          addr_next = addr;
          cnt_next  = CNT_W'(READ_LATENCY - 1);
          if (READ_LATENCY == 1) begin
            state_next = RP_ACK;
            load       = 1'b1;
          end else begin
            state_next = RP_WAIT;
          end
        end
      end
      RP_WAIT: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_next = RP_ACK;
          load       = 1'b1;
        end
      end
      RP_ACK:  state_next = RP_IDLE;
      default: state_next = RP_IDLE;
    endcase
  end

  // With single-cycle latency the load happens on the accept edge, before addr_q is valid.
  assign load_addr = (state == RP_IDLE) ? addr : addr_q;
  assign ack       = (state == RP_ACK);
endmodule

// File: rtl/risc_register_file.sv
// rtl/risc_register_file.sv - 32 x XLEN register file, x0 hardwired to zero, write-to-read bypass
module risc_register_file
  import risc_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  risc_register_file_if.slave bus
);
  logic [XLEN-1:0]       regs [NUM_REGS];
  reg_wr_state_t         wr_state, wr_state_next;
  logic                  wr_commit;
  logic [REG_ADDR_W-1:0] load_addr_a, load_addr_b;
  logic [XLEN-1:0]       value_a, value_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state;
    wr_commit     = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (bus.reg_wr_valid) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_ACK;
        end
      end
      WR_ACK:  wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  assign bus.reg_wr_ack = (wr_state == WR_ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit && (bus.reg_wr_addr != '0)) begin
      regs[bus.reg_wr_addr] <= bus.reg_wr_data;
    end
  end

  // A write committing on the load edge wins over the stale array contents.
  always_comb begin
    value_a = regs[load_addr_a];
    if (wr_commit && (bus.reg_wr_addr == load_addr_a)) value_a = bus.reg_wr_data;
    if (load_addr_a == '0) value_a = '0;
  end

  always_comb begin
    value_b = regs[load_addr_b];
    if (wr_commit && (bus.reg_wr_addr == load_addr_b)) value_b = bus.reg_wr_data;
    if (load_addr_b == '0) value_b = '0;
  end

  reg_read_port #(.READ_LATENCY(READ_LATENCY)) u_port_a (
    .clk        (clk),
    .reset      (reset),
    .valid      (bus.reg_rd_addr_a_valid),
    .addr       (bus.reg_rd_addr_a),
    .load_value (value_a),
    .load_addr  (load_addr_a),
    .data       (bus.reg_rd_data_a),
    .ack        (bus.reg_rd_data_a_ack)
  );

  reg_read_port #(.READ_LATENCY(READ_LATENCY)) u_port_b (
    .clk        (clk),
    .reset      (reset),
    .valid      (bus.reg_rd_addr_b_valid),
    .addr       (bus.reg_rd_addr_b),
    .load_value (value_b),
    .load_addr  (load_addr_b),
    .data       (bus.reg_rd_data_b),
    .ack        (bus.reg_rd_data_b_ack)
  );
endmodule

// File: tb/tb_risc_register_file.sv
// tb/tb_risc_register_file.sv - self-checking bench for the register file at latencies 1 and 3
module tb_risc_register_file;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  risc_register_file_if bus1 ();
  risc_register_file_if bus3 ();

  risc_register_file #(.READ_LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  risc_register_file #(.READ_LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  typedef struct {
    int          sel;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic ack_a(input int s);
    return (s != 0) ? bus3.reg_rd_data_a_ack : bus1.reg_rd_data_a_ack;
  endfunction
  function automatic logic ack_b(input int s);
    return (s != 0) ? bus3.reg_rd_data_b_ack : bus1.reg_rd_data_b_ack;
  endfunction
  function automatic logic [31:0] data_a(input int s);
    return (s != 0) ? bus3.reg_rd_data_a : bus1.reg_rd_data_a;
  endfunction
  function automatic logic [31:0] data_b(input int s);
    return (s != 0) ? bus3.reg_rd_data_b : bus1.reg_rd_data_b;
  endfunction
  function automatic logic wr_ack(input int s);
    return (s != 0) ? bus3.reg_wr_ack : bus1.reg_wr_ack;
  endfunction
  function automatic int lat(input int s);
    return (s != 0) ? 3 : 1;
  endfunction

  task automatic set_rd(input int s, input logic va, input logic [4:0] aa,
                        input logic vb, input logic [4:0] ab);
    if (s != 0) begin
      bus3.reg_rd_addr_a_valid = va; bus3.reg_rd_addr_a = aa;
      bus3.reg_rd_addr_b_valid = vb; bus3.reg_rd_addr_b = ab;
    end else begin
      bus1.reg_rd_addr_a_valid = va; bus1.reg_rd_addr_a = aa;
      bus1.reg_rd_addr_b_valid = vb; bus1.reg_rd_addr_b = ab;
    end
  endtask

  task automatic set_wr(input int s, input logic v, input logic [4:0] a, input logic [31:0] d);
    if (s != 0) begin
      bus3.reg_wr_valid = v; bus3.reg_wr_addr = a; bus3.reg_wr_data = d;
    end else begin
      bus1.reg_wr_valid = v; bus1.reg_wr_addr = a; bus1.reg_wr_data = d;
    end
  endtask

  task automatic do_write(input int s, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    set_wr(s, 1'b1, a, d);
    @(negedge clk);
    check("wr_ack", 32'(wr_ack(s)), 32'd1);
    set_wr(s, 1'b0, a, d);
    @(negedge clk);
    check("wr_ack_pulse", 32'(wr_ack(s)), 32'd0);
  endtask

  // Concurrent a/b read; optional write during cycle wr_at, addr_a swap after accept, hold through ack.
  task automatic do_read(input int s, input logic [4:0] aa, input logic [4:0] ab,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [4:0] alt_a,
                         input int wr_at, input logic [4:0] wa, input logic [31:0] wd,
                         input bit hold);
    exp_t e;
    int   start;
    bit   got = 1'b0;
    e.a = ea;
    e.b = eb;
    sb.push_back(e);
    @(negedge clk);
    set_rd(s, 1'b1, aa, 1'b1, ab);
    if (wr_at == 0) set_wr(s, 1'b1, wa, wd);
    start = cyc;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (wr_at >= 0 && k == wr_at) begin
        check("wr_ack_mid", 32'(wr_ack(s)), 32'd1);
        set_wr(s, 1'b0, wa, wd);
      end
      if (wr_at > 0 && k + 1 == wr_at) set_wr(s, 1'b1, wa, wd);
      if (k == 0) set_rd(s, 1'b1, alt_a, 1'b1, ab);
      if (ack_a(s) || ack_b(s)) begin
        got = 1'b1;
        check("ack_latency", 32'(cyc - start), 32'(lat(s)));
        check("ack_pair", 32'({ack_a(s), ack_b(s)}), 32'd3);
        e = sb.pop_front();
        check("data_a", data_a(s), e.a);
        check("data_b", data_b(s), e.b);
        if (hold) @(negedge clk);
        set_rd(s, 1'b0, alt_a, 1'b0, ab);
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    if (!got) begin
      e = sb.pop_front();
      set_rd(s, 1'b0, aa, 1'b0, ab);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{0, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{0, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[3] = '{1, 5'd5,  32'h0F0F0000, 5'd5,  5'd0,  32'h0F0F0000, 32'h0};
    vecs[4] = '{1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'h0F0F0000};
    vecs[5] = '{0, 5'd5,  32'h00000011, 5'd5,  5'd31, 32'h00000011, 32'hA5A5A5A5};

    for (int s = 0; s < 2; s++) begin
      set_rd(s, 1'b0, 5'd0, 1'b0, 5'd0);
      set_wr(s, 1'b0, 5'd0, 32'h0);
    end

    // Requests held during reset must never complete.
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      set_rd(s, 1'b1, 5'd3, 1'b1, 5'd4);
      set_wr(s, 1'b1, 5'd3, 32'h13579BDF);
    end
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check("rst_acks", 32'({ack_a(s), ack_b(s), wr_ack(s)}), 32'd0);
        check("rst_data_a", data_a(s), 32'h0);
        check("rst_data_b", data_b(s), 32'h0);
      end
    end
    for (int s = 0; s < 2; s++) begin
      set_rd(s, 1'b0, 5'd0, 1'b0, 5'd0);
      set_wr(s, 1'b0, 5'd0, 32'h0);
    end
    reset = 1'b1;

    for (int i = 0; i < 32; i++)
      do_read(0, 5'(i), 5'(31 - i), 32'h0, 32'h0, 5'(i), -1, 5'd0, 32'h0, 1'b0);
    for (int i = 3; i < 32; i += 7)
      do_read(1, 5'(i), 5'(i + 1), 32'h0, 32'h0, 5'(i), -1, 5'd0, 32'h0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      do_write(vecs[v].sel, vecs[v].wa, vecs[v].wd);
      do_read(vecs[v].sel, vecs[v].ra, vecs[v].rb, vecs[v].ea, vecs[v].eb, vecs[v].ra,
              -1, 5'd0, 32'h0, 1'b0);
    end

    // Write on the data-load edge (L=3), on the accept edge (L=3), and on the load edge (L=1).
    do_read(1, 5'd7, 5'd7, 32'h55, 32'h55, 5'd7, 2, 5'd7, 32'h55, 1'b0);
    do_read(1, 5'd7, 5'd0, 32'h55, 32'h0, 5'd7, -1, 5'd0, 32'h0, 1'b0);
    do_read(1, 5'd9, 5'd7, 32'h99, 32'h55, 5'd9, 0, 5'd9, 32'h99, 1'b0);
    do_read(0, 5'd9, 5'd9, 32'h77, 32'h77, 5'd9, 0, 5'd9, 32'h77, 1'b0);

    do_read(1, 5'd7, 5'd9, 32'h55, 32'h99, 5'd7, -1, 5'd0, 32'h0, 1'b1);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_a(1) || ack_b(1)) n++;
    end
    check("single_ack", 32'(n), 32'd0);
    check("data_stable", data_a(1), 32'h55);

    do_read(1, 5'd7, 5'd9, 32'h55, 32'h99, 5'd5, -1, 5'd0, 32'h0, 1'b0);

    // Reset while the L=3 ports sit in WAIT.
    @(negedge clk);
    set_rd(1, 1'b1, 5'd7, 1'b1, 5'd9);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("wait_rst_acks", 32'({ack_a(1), ack_b(1)}), 32'd0);
      check("wait_rst_data", data_a(1) | data_b(1), 32'h0);
    end
    set_rd(1, 1'b0, 5'd7, 1'b0, 5'd9);
    reset = 1'b1;
    do_read(1, 5'd7, 5'd9, 32'h0, 32'h0, 5'd7, -1, 5'd0, 32'h0, 1'b0);
    do_write(1, 5'd7, 32'hCAFEF00D);
    do_read(1, 5'd7, 5'd0, 32'hCAFEF00D, 32'h0, 5'd7, -1, 5'd0, 32'h0, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
